// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative radix-2 multiply/divide engine with HI/LO result registers
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only in IDLE
//   op     in   00 multu, 01 mult, 10 divu, 11 div
//   a, b   in   rs / rt operands, sampled with start
//   busy   out  operation in flight
//   done   out  one-cycle pulse, hi/lo valid in the same cycle
//   hi/lo  out  product high/low, or remainder/quotient
//   div0   out  sticky flag: last divide had b==0
module muldiv_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div0
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;
    state_t state, state_nx;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   ma, mb, mag_a, mag_b;
    logic [2*WIDTH-1:0] acc, acc_step, prod_fix;
    logic [CW-1:0]      cnt;
    logic               neg_q, neg_r, b_zero;
    logic [WIDTH:0]     mul_sum, div_r, div_d;
    logic               div_ge;
    logic [WIDTH-1:0]   q_fix, r_fix;
    assign b_zero = op_r[1] && mb == '0;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? PREP : IDLE;
            PREP:    state_nx = b_zero ? FIX : RUN;
            RUN:     state_nx = cnt == '0 ? FIX : RUN;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        mag_a    = (op_r[0] && ma[WIDTH-1]) ? -ma : ma;
        mag_b    = (op_r[0] && mb[WIDTH-1]) ? -mb : mb;
        // multiply: acc = {partial product, remaining multiplier bits}
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, ma} : '0);
        // divide: acc = {partial remainder, remaining dividend / growing quotient}
        div_r    = acc[2*WIDTH-1:WIDTH-1];
        div_ge   = div_r >= {1'b0, mb};
        div_d    = div_r - {1'b0, mb};
        acc_step = op_r[1] ? {div_ge ? div_d[WIDTH-1:0] : div_r[WIDTH-1:0], acc[WIDTH-2:0], div_ge}
                           : {mul_sum, acc[WIDTH-1:1]};
        prod_fix = neg_q ? -acc : acc;
        q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            div0  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            op_r  <= '0;
            ma    <= '0;
            mb    <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= state == FIX;
            case (state)
                IDLE: if (start) begin
                    op_r <= op;
                    ma   <= a;
                    mb   <= b;
                    div0 <= 1'b0;
                    busy <= 1'b1;
                end
                PREP: begin
                    ma    <= mag_a;
                    mb    <= mag_b;
                    neg_q <= op_r[0] && (ma[WIDTH-1] ^ mb[WIDTH-1]);
                    neg_r <= op_r[0] && op_r[1] && ma[WIDTH-1];
                    acc   <= b_zero ? '0 : {{WIDTH{1'b0}}, op_r[1] ? mag_a : mag_b};
                    div0  <= b_zero;
                    cnt   <= CW'(WIDTH - 1);
                end
                RUN: begin
                    acc <= acc_step;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                default: begin
                    hi   <= op_r[1] ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
                    lo   <= op_r[1] ? q_fix : prod_fix[WIDTH-1:0];
                    busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, div0;
    logic [15:0] hi, lo;
    int n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
    muldiv_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div0(div0)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // issue one op; returns cycles from accept edge to done and busy-high samples
    task automatic do_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                         output int lat, output int bc);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; bc = 0;
        while (!done && lat < 40) begin
            bc += int'(busy);
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 40) check("timeout", 32'(lat), 32'd18);
    endtask
    initial begin
        int lat, bc, dn;
        logic [15:0] hi_s, lo_s;
        #12;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_hilo", {hi, lo}, 32'h0);
        check("rst_div0", {31'b0, div0}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        // 1: multu max*max
        do_op(2'b00, 16'hFFFF, 16'hFFFF, lat, bc);
        check("t1_lat", 32'(lat), 32'd18);
        check("t1_busy", 32'(bc), 32'd18);
        check("t1_busy_done", {31'b0, busy}, 32'd0);
        check("t1_hilo", {hi, lo}, 32'hFFFE_0001);
        check("t1_div0", {31'b0, div0}, 32'd0);
        // 2: mult then back-to-back div started in the done cycle
        do_op(2'b01, 16'hFFFD, 16'h0005, lat, bc);
        check("t2_mult", {hi, lo}, 32'hFFFF_FFF1);
        do_op(2'b11, 16'hFFF9, 16'h0002, lat, bc);
        check("t2_b2b_lat", 32'(lat), 32'd18);
        check("t2_div", {hi, lo}, 32'hFFFF_FFFD);
        @(posedge clk); #1;
        check("t2_done_pulse", {31'b0, done}, 32'd0);
        // 3: divide by zero, then flag clears
        do_op(2'b10, 16'd100, 16'd0, lat, bc);
        check("t3_lat", 32'(lat), 32'd2);
        check("t3_busy", 32'(bc), 32'd2);
        check("t3_hilo", {hi, lo}, 32'h0);
        check("t3_div0", {31'b0, div0}, 32'd1);
        do_op(2'b10, 16'd100, 16'd7, lat, bc);
        check("t3_div0_clr", {31'b0, div0}, 32'd0);
        check("t3_divu", {hi, lo}, {16'd2, 16'd14});
        // 4: signed overflow and unsigned large divisor
        do_op(2'b11, 16'h8000, 16'hFFFF, lat, bc);
        check("t4_div_ovf", {hi, lo}, 32'h0000_8000);
        do_op(2'b10, 16'h8000, 16'hFFFF, lat, bc);
        check("t4_divu", {hi, lo}, 32'h8000_0000);
        do_op(2'b11, 16'd7, 16'hFFFE, lat, bc);
        check("t4_div_pos_neg", {hi, lo}, 32'h0001_FFFD);
        do_op(2'b01, 16'hFFFF, 16'hFFFF, lat, bc);
        check("t4_mult_nn", {hi, lo}, 32'h0000_0001);
        // 5: start pulses and operand changes while busy are ignored
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 16'd7; b = 16'd9;
        @(posedge clk); #1;
        start = 1'b0;
        dn = 0; hi_s = '0; lo_s = '0;
        for (int i = 1; i <= 25; i++) begin
            if (i == 5) begin start = 1'b1; a = 16'd1; b = 16'd1; end
            else if (i == 6) begin start = 1'b0; a = 16'd5; b = 16'd5; end
            @(posedge clk); #1;
            if (done) begin dn++; hi_s = hi; lo_s = lo; end
        end
        check("t5_pulses", 32'(dn), 32'd1);
        check("t5_hilo", {hi_s, lo_s}, 32'd63);
        // 6: reset mid-operation
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 16'd200; b = 16'd300;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        check("t6_rst_busy", {31'b0, busy}, 32'd0);
        check("t6_rst_hilo", {hi, lo}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        check("t6_no_done", 32'(dn), 32'd0);
        check("t6_idle_busy", {31'b0, busy}, 32'd0);
        do_op(2'b00, 16'd3, 16'd4, lat, bc);
        check("t6_lat", 32'(lat), 32'd18);
        check("t6_hilo", {hi, lo}, 32'd12);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
